// File: rtl/fp_operand_front_pkg.sv
// Shared types, constants and classification helpers for the adder operand front end.
package fp_operand_front_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StIssue,
    StBusy,
    StSpecial
  } front_state_e;

  // Single-precision reference values; the top rebuilds them for its own widths
  localparam logic [31:0] QNan    = 32'h7FC0_0000;
  localparam logic [7:0]  ExpOnes = 8'hFF;

  function automatic logic is_nan(input logic exp_ones, input logic frac_nz);
    return exp_ones & frac_nz;
  endfunction

  function automatic logic is_inf(input logic exp_ones, input logic frac_nz);
    return exp_ones & ~frac_nz;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one packed operand into sign, effective exponent and mantissa with hidden bit.
module fp_unpack
  import fp_operand_front_pkg::*;
#(
  parameter int unsigned ExpBits      = 8,
  parameter int unsigned MantissaBits = 23,
  parameter int unsigned Width        = 1 + ExpBits + MantissaBits
) (
  input  logic [Width-1:0]      op,
  output logic                  sign,
  output logic [ExpBits-1:0]    exp_eff,
  output logic [MantissaBits:0] mant,
  output logic                  nan,
  output logic                  inf
);

  logic [ExpBits-1:0]      exp_field;
  logic [MantissaBits-1:0] frac;
  logic                    exp_zero;
  logic                    exp_ones;
  logic                    frac_nz;

  always_comb begin
    exp_field = op[Width-2 -: ExpBits];
    frac      = op[MantissaBits-1:0];
    exp_zero  = (exp_field == '0);
    exp_ones  = &exp_field;
    frac_nz   = |frac;
    sign      = op[Width-1];
    // Denormals share the exponent of the smallest normal, without the hidden one
    exp_eff   = exp_zero ? ExpBits'(1) : exp_field;
    mant      = {~exp_zero, frac};
    nan       = is_nan(exp_ones, frac_nz);
    inf       = is_inf(exp_ones, frac_nz);
  end

endmodule

// File: rtl/fp_operand_front.sv
// Operand capture, unpack and exponent compare ahead of the adder Control FSM.
module fp_operand_front
  import fp_operand_front_pkg::*;
#(
  parameter int unsigned ExpBits      = 8,
  parameter int unsigned MantissaBits = 23,
  parameter int unsigned Width        = 1 + ExpBits + MantissaBits
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [Width-1:0]        a,
  input  logic [Width-1:0]        b,
  input  logic                    add_done,
  output logic                    go,
  output logic                    exp_set,
  output logic [ExpBits-1:0]      exp_diff,
  output logic [ExpBits-1:0]      big_exp,
  output logic [MantissaBits:0]   mant_a,
  output logic [MantissaBits:0]   mant_b,
  output logic                    sign_a,
  output logic                    sign_b,
  output logic                    spec_valid,
  output logic [Width-1:0]        spec_result
);

  localparam logic [Width-1:0] QNanLocal =
    {1'b0, {ExpBits{1'b1}}, 1'b1, {(MantissaBits - 1){1'b0}}};

  front_state_e state_q, state_d;

  logic [Width-1:0] a_q, b_q;

  logic                  un_sign_a, un_sign_b;
  logic [ExpBits-1:0]    un_exp_a, un_exp_b;
  logic [MantissaBits:0] un_mant_a, un_mant_b;
  logic                  nan_a, nan_b, inf_a, inf_b;

  logic                  special;
  logic [Width-1:0]      special_value;
  logic [ExpBits:0]      diff_wide;
  logic [ExpBits:0]      diff_neg;
  logic                  exp_ge;
  logic [ExpBits-1:0]    diff_mag;
  logic [ExpBits-1:0]    exp_max;

  fp_unpack #(
    .ExpBits     (ExpBits),
    .MantissaBits(MantissaBits),
    .Width       (Width)
  ) u_unpack_a (
    .op     (a_q),
    .sign   (un_sign_a),
    .exp_eff(un_exp_a),
    .mant   (un_mant_a),
    .nan    (nan_a),
    .inf    (inf_a)
  );

  fp_unpack #(
    .ExpBits     (ExpBits),
    .MantissaBits(MantissaBits),
    .Width       (Width)
  ) u_unpack_b (
    .op     (b_q),
    .sign   (un_sign_b),
    .exp_eff(un_exp_b),
    .mant   (un_mant_b),
    .nan    (nan_b),
    .inf    (inf_b)
  );

  // Extra bit keeps the borrow so the sign of the difference gives the ordering
  always_comb begin
    diff_wide = {1'b0, un_exp_a} - {1'b0, un_exp_b};
    diff_neg  = -diff_wide;
    exp_ge    = ~diff_wide[ExpBits];
    diff_mag  = exp_ge ? diff_wide[ExpBits-1:0] : diff_neg[ExpBits-1:0];
    exp_max   = exp_ge ? un_exp_a : un_exp_b;
  end

  always_comb begin
    special       = nan_a | nan_b | inf_a | inf_b;
    special_value = b_q;
    if (nan_a || nan_b || (inf_a && inf_b && (un_sign_a != un_sign_b))) begin
      special_value = QNanLocal;
    end else if (inf_a) begin
      special_value = a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid) state_d = StCapture;
      StCapture: state_d = special ? StSpecial : StIssue;
      StIssue:   state_d = StBusy;
      StBusy:    if (add_done) state_d = StIdle;
      StSpecial: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    go         = (state_q == StIssue);
    spec_valid = (state_q == StSpecial);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      exp_set     <= 1'b0;
      exp_diff    <= '0;
      big_exp     <= '0;
      mant_a      <= '0;
      mant_b      <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      spec_result <= '0;
    end else begin
      if (state_q == StIdle && in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      if (state_q == StCapture) begin
        exp_set  <= exp_ge;
        exp_diff <= diff_mag;
        big_exp  <= exp_max;
        mant_a   <= un_mant_a;
        mant_b   <= un_mant_b;
        sign_a   <= un_sign_a;
        sign_b   <= un_sign_b;
        if (special) spec_result <= special_value;
      end
    end
  end

endmodule

// File: tb/tb_fp_operand_front.sv
// Directed bench with a result scoreboard for fp_operand_front (single precision).
module tb_fp_operand_front;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, add_done, go, exp_set;
  logic        sign_a, sign_b, spec_valid;
  logic [31:0] a, b, spec_result;
  logic [7:0]  exp_diff, big_exp;
  logic [23:0] mant_a, mant_b;

  always #5 clk = ~clk;

  fp_operand_front #(
    .ExpBits     (8),
    .MantissaBits(23),
    .Width       (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .add_done   (add_done),
    .go         (go),
    .exp_set    (exp_set),
    .exp_diff   (exp_diff),
    .big_exp    (big_exp),
    .mant_a     (mant_a),
    .mant_b     (mant_b),
    .sign_a     (sign_a),
    .sign_b     (sign_b),
    .spec_valid (spec_valid),
    .spec_result(spec_result)
  );

  typedef struct {
    logic        is_spec;
    logic        exp_set;
    logic [7:0]  diff;
    logic [7:0]  big;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        sa;
    logic        sb;
    logic [31:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t m;
    logic [7:0] fx, fy, ex, ey;
    logic nan_x, nan_y, inf_x, inf_y;
    fx    = x[30:23];
    fy    = y[30:23];
    ex    = (fx == 8'd0) ? 8'd1 : fx;
    ey    = (fy == 8'd0) ? 8'd1 : fy;
    nan_x = (fx == 8'hFF) && (x[22:0] != 23'd0);
    nan_y = (fy == 8'hFF) && (y[22:0] != 23'd0);
    inf_x = (fx == 8'hFF) && (x[22:0] == 23'd0);
    inf_y = (fy == 8'hFF) && (y[22:0] == 23'd0);
    m.is_spec = (fx == 8'hFF) || (fy == 8'hFF);
    m.exp_set = (ex >= ey);
    m.diff    = (ex >= ey) ? ex - ey : ey - ex;
    m.big     = (ex >= ey) ? ex : ey;
    m.ma      = {fx != 8'd0, x[22:0]};
    m.mb      = {fy != 8'd0, y[22:0]};
    m.sa      = x[31];
    m.sb      = y[31];
    if (nan_x || nan_y || (inf_x && inf_y && (x[31] != y[31]))) m.res = 32'h7FC0_0000;
    else if (inf_x) m.res = x;
    else m.res = y;
    return m;
  endfunction

  // Scoreboard: every Go or SpecValid must match the oldest pending pair
  always @(negedge clk) begin
    if (rst_n && (go || spec_valid)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", {30'd0, go, spec_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_kind", {30'd0, go, spec_valid}, {30'd0, ~e.is_spec, e.is_spec});
        if (e.is_spec) begin
          chk("sb_spec_result", spec_result, e.res);
        end else begin
          chk("sb_exp", {15'd0, exp_set, exp_diff, big_exp}, {15'd0, e.exp_set, e.diff, e.big});
          chk("sb_mant_a", {8'd0, mant_a}, {8'd0, e.ma});
          chk("sb_mant_b", {8'd0, mant_b}, {8'd0, e.mb});
          chk("sb_signs", {30'd0, sign_a, sign_b}, {30'd0, e.sa, e.sb});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb_q.push_back(model(x, y));
  endtask

  task automatic finish_add();
    add_done = 1'b1;
    step();
    add_done = 1'b0;
    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] sp_a [3] = '{32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000};
  logic [31:0] sp_b [3] = '{32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000};
  logic [31:0] sp_r [3] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    add_done = 1'b0;
    a        = '0;
    b        = '0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_outs", {13'd0, go, exp_set, exp_diff, big_exp, sign_a, sign_b, spec_valid}, 32'd0);
    chk("rst_mants", {mant_a[15:0], mant_b[15:0]}, 32'd0);
    chk("rst_spec", spec_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 2.0: Go two cycles after acceptance
    send(32'h3F80_0000, 32'h4000_0000);
    step();
    in_valid = 1'b0;
    chk("t1_capture", {30'd0, in_ready, go}, 32'd0);
    step();
    chk("t1_go", {31'd0, go}, 32'd1);
    chk("t1_exp", {15'd0, exp_set, exp_diff, big_exp}, {15'd0, 1'b0, 8'd1, 8'd128});
    chk("t1_mants", {mant_a[23:8], mant_b[23:8]}, 32'h8000_8000);
    step();
    chk("t1_go_off", {31'd0, go}, 32'd0);
    finish_add();

    // Equal exponents, then hold in BUSY while InValid is ignored
    send(32'h3F80_0000, 32'h3F80_0000);
    step();
    in_valid = 1'b0;
    step();
    chk("t2_go", {31'd0, go}, 32'd1);
    step();
    for (int i = 0; i < 10; i++) begin
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      step();
      chk("t2_busy_ready", {30'd0, in_ready, go}, 32'd0);
      chk("t2_busy_hold", {15'd0, exp_set, exp_diff, big_exp}, {15'd0, 1'b1, 8'd0, 8'd127});
      chk("t2_busy_mant", {8'd0, mant_a}, 32'h0080_0000);
    end
    in_valid = 1'b0;
    finish_add();

    // Denormal against smallest normal
    send(32'h0000_0001, 32'h0080_0000);
    step();
    in_valid = 1'b0;
    step();
    chk("t3_exp", {15'd0, exp_set, exp_diff, big_exp}, {15'd0, 1'b1, 8'd0, 8'd1});
    chk("t3_mant_a", {8'd0, mant_a}, 32'h0000_0001);
    chk("t3_mant_b", {8'd0, mant_b}, 32'h0080_0000);
    step();
    finish_add();

    // NaN / Inf handled locally
    for (int i = 0; i < 3; i++) begin
      send(sp_a[i], sp_b[i]);
      step();
      in_valid = 1'b0;
      chk("t4_capture", {30'd0, spec_valid, go}, 32'd0);
      step();
      chk("t4_spec_pulse", {30'd0, spec_valid, go}, 32'd2);
      chk("t4_spec_result", spec_result, sp_r[i]);
      step();
      chk("t4_after", {29'd0, spec_valid, go, in_ready}, 32'd1);
    end

    // Asynchronous reset while BUSY
    send(32'h3F80_0000, 32'h4000_0000);
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_rst_outs", {13'd0, go, exp_set, exp_diff, big_exp, sign_a, sign_b, spec_valid}, 32'd0);
    chk("t5_rst_mants", {mant_a[15:0], mant_b[15:0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("t5_no_go", {30'd0, go, spec_valid}, 32'd0);
    send(32'h4040_0000, 32'hBE80_0000);
    step();
    in_valid = 1'b0;
    step();
    chk("t5_go", {31'd0, go}, 32'd1);
    chk("t5_exp", {15'd0, exp_set, exp_diff, big_exp}, {15'd0, 1'b1, 8'd3, 8'd128});
    chk("t5_mant_a", {8'd0, mant_a}, 32'h00C0_0000);
    step();
    finish_add();

    // AddDone during CAPTURE is ignored; AddDone with InValid in BUSY has no bypass
    send(32'h4000_0000, 32'h3F00_0000);
    step();
    in_valid = 1'b0;
    add_done = 1'b1;
    step();
    add_done = 1'b0;
    chk("t6_go", {31'd0, go}, 32'd1);
    chk("t6_diff", {24'd0, exp_diff}, 32'd2);
    step();
    chk("t6_busy", {31'd0, in_ready}, 32'd0);
    send(32'h3F80_0000, 32'h4120_0000);
    add_done = 1'b1;
    step();
    add_done = 1'b0;
    chk("t6_idle", {30'd0, in_ready, go}, 32'd2);
    step();
    in_valid = 1'b0;
    chk("t6_accepted", {31'd0, in_ready}, 32'd0);
    step();
    chk("t6_go2", {31'd0, go}, 32'd1);
    chk("t6_exp2", {15'd0, exp_set, exp_diff, big_exp}, {15'd0, 1'b0, 8'd3, 8'd130});
    chk("t6_mant_b", {8'd0, mant_b}, 32'h00A0_0000);
    step();
    finish_add();

    step();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_operand_front.md
Name: fp_operand_front

Overview:
- Input stage of the fixed-point/IEEE-754 adder datapath, directly upstream of the adder Control FSM.
- Accepts an operand pair through a valid/ready handshake and unpacks each operand into sign, effective exponent and mantissa with hidden bit.
- Computes exponent ordering (ExpSet) and magnitude difference (ExpDiff), then issues a one-cycle Go to Control.
- Holds all operand outputs stable until Control reports completion.
- Handles NaN/Inf operands locally; these never reach Control.

Parameters:
- EXPBITS, 8, exponent field width
- MANTISSABITS, 23, stored fraction width
- WIDTH, 1+EXPBITS+MANTISSABITS, packed operand width

Ports:
- Clock  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- InValid  in  1  operand pair A/B valid
- InReady  out  1  block can accept a pair
- A  in  WIDTH  packed operand A
- B  in  WIDTH  packed operand B
- AddDone  in  1  Control/normaliser finished the current add
- Go  out  1  one-cycle start pulse to Control
- ExpSet  out  1  1 when ExpA >= ExpB
- ExpDiff  out  EXPBITS  |ExpA - ExpB| (effective exponents)
- BigExp  out  EXPBITS  max(ExpA, ExpB)
- MantA, MantB  out  MANTISSABITS+1  mantissas including hidden bit
- SignA, SignB  out  1  operand signs
- SpecValid  out  1  one-cycle pulse: special result available
- SpecResult  out  WIDTH  special-case result

Behaviour:
- Reset (ResetN=0, asynchronous): state=IDLE. All outputs 0 except InReady=1.
- FSM states: IDLE, CAPTURE, ISSUE, BUSY, SPECIAL.
- IDLE:
  - InReady=1.
  - On InValid&&InReady at an edge: register A and B, go to CAPTURE.
- CAPTURE (InReady=0):
  - Unpack both operands.
  - Exponent field 0 → effective exponent 1, hidden bit 0. Otherwise hidden bit 1.
  - Register ExpSet, ExpDiff, BigExp, MantA/B, SignA/B.
  - If either operand has exponent all-ones → SPECIAL; else → ISSUE.
- ISSUE:
  - Go=1 for exactly one cycle, then → BUSY.
  - Go is asserted 2 cycles after the accepting edge.
- BUSY:
  - Hold all datapath outputs unchanged.
  - On AddDone → IDLE. Outputs stay at last values; only InReady rises.
- SPECIAL:
  - SpecValid=1 for one cycle, then → IDLE. Go is never asserted.
  - Either operand NaN (exp all-ones, fraction≠0) → SpecResult=0x7FC00000 (quiet NaN, scaled to parameters).
  - +Inf with -Inf → quiet NaN.
  - Inf with finite, or Inf with same-sign Inf → that Inf.
- Arithmetic:
  - ExpDiff is computed in EXPBITS+1 bits and the magnitude is truncated to EXPBITS; it cannot overflow.
  - Equal exponents → ExpSet=1, ExpDiff=0.
  - The block does not saturate ExpDiff; Control clamps it to MANTISSABITS.
- Boundary conditions:
  - InValid outside IDLE is ignored, and A/B are not sampled.
  - AddDone outside BUSY is ignored.
  - AddDone and a new InValid in the same cycle: the new pair is accepted only on the following IDLE cycle (no bypass).
  - Reset mid-operation aborts immediately. No Go or SpecValid is produced afterwards.

Decomposition:
- Shared package fpfrontpkg:
  - FrontStateType enum {IDLE, CAPTURE, ISSUE, BUSY, SPECIAL}.
  - Constants QNAN and EXPONES.
  - Function isNaN/isInf.
- Sub-module fp_unpack: combinational; one operand → sign, effective exponent, mantissa with hidden bit, isNaN, isInf. Instantiated twice.

Test Plan:
- A=0x3F800000, B=0x40000000, InValid at cycle 0 → cycle 2: Go=1, ExpSet=0, ExpDiff=1, BigExp=128, MantA=MantB=0x800000.
- A=B=0x3F800000 → ExpSet=1, ExpDiff=0, Go one cycle. Hold in BUSY for 10 cycles with InValid=1 → InReady=0 and outputs unchanged. AddDone → InReady=1 next cycle.
- A=0x00000001, B=0x00800000 (denormal) → ExpDiff=0, MantA=0x000001, MantB=0x800000, ExpSet=1.
- A=0x7FC00000, B=0x3F800000 → SpecValid=1 for one cycle, SpecResult=0x7FC00000, Go never asserted. A=0x7F800000, B=0xFF800000 → 0x7FC00000. A=0xFF800000, B=0x3F800000 → 0xFF800000.
- Reset pulse (ResetN=0 asynchronous) during BUSY → all outputs 0 and InReady=1 before the next edge. A subsequent pair is processed normally.
- AddDone asserted during CAPTURE → ignored; Go still issued. InValid and AddDone simultaneous in BUSY → pair accepted one cycle later.
